piso_serializer: RTL and testbench

Parallel-in, serial-out counterpart to the team's N-bit parallel register: accepts an N-bit word through a valid/ready load handshake and shifts it out one bit per enabled clock, LSB first. It provides ser_valid and ser_last framing so a downstream serial consumer can delimit words. Back-to-back words stream with no idle gap.

---
 rtl/piso_serializer.sv | 93 +++++++++
 tb/tb_piso_serializer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out shifter: accepts an N-bit word on a valid/ready handshake and emits it
// LSB first, one bit per enabled clock, with valid/last framing and a registered done pulse.
module piso_serializer #(
  parameter int unsigned N = 8,
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] data_in,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic         shift_en,
  output logic         ser_out,
  output logic         ser_valid,
  output logic         ser_last,
  output logic         done
);

  typedef enum logic {StIdle, StShift} state_e;

  state_e         r_state, w_state_d;
  logic [N-1:0]   r_shreg, w_shreg_d;
  logic [CW-1:0]  r_count, w_count_d;
  logic           r_done, w_done_d;
  logic           w_last;

  assign w_last = (r_state == StShift) && (r_count == CW'(N - 1));

  always_comb begin
    w_state_d = r_state;
    w_shreg_d = r_shreg;
    w_count_d = r_count;
    w_done_d  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (load_valid) begin
          w_shreg_d = data_in;
          w_count_d = '0;
          w_state_d = StShift;
        end
      end
      StShift: begin
        if (shift_en) begin
          if (w_last) begin
            w_done_d = 1'b1;
            // A word offered during the last bit is taken with no bubble.
            if (load_valid) begin
              w_shreg_d = data_in;
              w_count_d = '0;
            end else begin
              w_state_d = StIdle;
            end
          end else begin
            w_shreg_d = r_shreg >> 1;
            w_count_d = r_count + CW'(1);
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
      r_shreg <= '0;
      r_count <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_shreg <= w_shreg_d;
      r_count <= w_count_d;
      r_done  <= w_done_d;
    end
  end

  // Outputs are forced quiet while reset is held, independent of the clock.
  always_comb begin
    load_ready = 1'b0;
    ser_valid  = 1'b0;
    ser_last   = 1'b0;
    ser_out    = 1'b0;
    if (!reset) begin
      load_ready = (r_state == StIdle) || (w_last && shift_en);
      ser_valid  = (r_state == StShift);
      ser_last   = w_last;
      ser_out    = (r_state == StShift) && r_shreg[0];
    end
  end

  assign done = r_done;

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: accepted words become queues of expected (bit, last)
// pairs; a negedge monitor compares serial output, framing, load_ready and done against them.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_in = '0;
  logic       load_valid = 1'b0;
  logic       load_ready;
  logic       shift_en = 1'b0;
  logic       ser_out, ser_valid, ser_last, done;

  logic [0:0] d1 = '0;
  logic       lv1 = 1'b0, se1 = 1'b0;
  logic       lr1, so1, sv1, sl1, dn1;

  int checks = 0;
  int errors = 0;
  int mode = 0;

  bit qb[$];
  bit ql[$];
  bit pend = 1'b0;

  always #5 clk = ~clk;

  piso_serializer #(.N(8)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .load_valid(load_valid),
    .load_ready(load_ready), .shift_en(shift_en), .ser_out(ser_out),
    .ser_valid(ser_valid), .ser_last(ser_last), .done(done)
  );

  piso_serializer #(.N(1)) dut1 (
    .clk(clk), .reset(reset), .data_in(d1), .load_valid(lv1),
    .load_ready(lr1), .shift_en(se1), .ser_out(so1),
    .ser_valid(sv1), .ser_last(sl1), .done(dn1)
  );

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // shift_en pattern: 0 = always on, 1 = toggling, 2 = random
  always @(posedge clk) begin
    #1;
    case (mode)
      0: shift_en = 1'b1;
      1: shift_en = ~shift_en;
      default: shift_en = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin
    if (reset) begin
      pend = 1'b0;
    end else begin
      chk("done", done, pend);
      pend = 1'b0;
      chk("ser_valid", ser_valid, qb.size() != 0);
      if (qb.size() == 0) begin
        chk("load_ready_idle", load_ready, 1'b1);
        chk("ser_out_idle", ser_out, 1'b0);
        chk("ser_last_idle", ser_last, 1'b0);
      end else begin
        chk("ser_out", ser_out, qb[0]);
        chk("ser_last", ser_last, ql[0]);
        chk("load_ready_shift", load_ready, ql[0] && shift_en);
        if (shift_en) begin
          pend = ql[0];
          void'(qb.pop_front());
          void'(ql.pop_front());
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that accepted the word.
  task automatic load_word(input logic [7:0] w);
    bit fired = 1'b0;
    data_in = w;
    load_valid = 1'b1;
    for (int i = 0; i < 200 && !fired; i++) begin
      @(negedge clk);
      if (load_ready) fired = 1'b1;
    end
    if (!fired) begin
      errors++;
      $display("FAIL load_timeout: word %h never accepted", w);
    end
    @(posedge clk);
    if (fired) begin
      for (int b = 0; b < 8; b++) begin
        qb.push_back(w[b]);
        ql.push_back(b == 7);
      end
    end
    #1;
    load_valid = 1'b0;
  endtask

  task automatic wait_cycles(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic drain;
    mode = 0;
    for (int i = 0; i < 100 && qb.size() != 0; i++) @(posedge clk);
    chk("drain_empty", qb.size() == 0, 1'b1);
    wait_cycles(2);
  endtask

  initial begin
    @(negedge clk);
    chk("rst_load_ready", load_ready, 1'b0);
    chk("rst_ser_valid", ser_valid, 1'b0);
    chk("rst_done", done, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    wait_cycles(5);

    load_word(8'hA5);
    wait_cycles(12);

    mode = 1;
    load_word(8'h3C);
    drain();

    load_word(8'hFF);
    load_word(8'h01);
    drain();

    load_word(8'hF0);
    wait_cycles(2);
    reset = 1'b1;
    qb.delete();
    ql.delete();
    @(negedge clk);
    chk("midrst_ser_valid", ser_valid, 1'b0);
    chk("midrst_load_ready", load_ready, 1'b0);
    chk("midrst_ser_out", ser_out, 1'b0);
    chk("midrst_done", done, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    wait_cycles(3);
    load_word(8'h81);
    drain();

    for (int n = 0; n < 30; n++) begin
      int gap;
      mode = int'($urandom_range(0, 2));
      load_word(8'($urandom));
      gap = int'($urandom_range(0, 3));
      if (gap != 0) wait_cycles(gap);
    end
    drain();

    // N=1: two words back-to-back, each consumed in a single enabled cycle.
    d1 = 1'b1;
    lv1 = 1'b1;
    se1 = 1'b1;
    @(negedge clk);
    chk("n1_ready_idle", lr1, 1'b1);
    @(posedge clk);
    #1;
    d1 = 1'b0;
    @(negedge clk);
    chk("n1_out0", so1, 1'b1);
    chk("n1_last0", sl1, 1'b1);
    chk("n1_ready0", lr1, 1'b1);
    @(posedge clk);
    #1;
    lv1 = 1'b0;
    @(negedge clk);
    chk("n1_out1", so1, 1'b0);
    chk("n1_valid1", sv1, 1'b1);
    chk("n1_last1", sl1, 1'b1);
    chk("n1_done0", dn1, 1'b1);
    @(negedge clk);
    chk("n1_done1", dn1, 1'b1);
    chk("n1_idle", sv1, 1'b0);
    @(negedge clk);
    chk("n1_done_clear", dn1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
